// File: rtl/vec_lsu_initiator.sv
// Load/store initiator between vector decode and the 512x32 data memory.
// Owns a small vector register file that LOAD fills and STORE drains, one command at a time.
module vec_lsu_initiator #(
    parameter int  ADDR_W = 9,
    parameter int  WORD_W = 32,
    parameter int  LANES  = 16,
    parameter int  NREGS  = 4,
    localparam int VW     = LANES * WORD_W,
    localparam int RSEL_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [RSEL_W-1:0] cmd_reg,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_err,
    output logic              resp_wrap,
    input  logic              vr_wr_en,
    input  logic [RSEL_W-1:0] vr_wr_sel,
    input  logic [VW-1:0]     vr_wr_data,
    input  logic [RSEL_W-1:0] vr_rd_sel,
    output logic [VW-1:0]     vr_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [VW-1:0]     mem_wdata,
    input  logic [VW-1:0]     mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;

    // Highest base address whose 16-lane window still fits below the top of memory.
    localparam int WRAP_LIMIT = (1 << ADDR_W) - LANES;

    logic [1:0]        state;
    logic              op_store;
    logic [RSEL_W-1:0] lat_reg;
    logic [ADDR_W-1:0] lat_addr;
    logic [VW-1:0]     vregs [NREGS];

    logic accept;
    logic legal;
    logic load_capture;
    logic resp_take;

    assign cmd_ready    = (state == ST_IDLE);
    assign resp_valid   = (state == ST_RESP);
    assign accept       = cmd_valid && cmd_ready;
    assign legal        = (cmd_op == OP_LOAD) || (cmd_op == OP_STORE);
    assign resp_take    = resp_valid && resp_ready;
    assign load_capture = (state == ST_EXEC) && !op_store;
    assign vr_rd_data   = vregs[vr_rd_sel];

    // Memory pins are registered at accept so they are stable for the whole EXEC cycle;
    // the store data is therefore the source register as it stood at the accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_store  <= 1'b0;
            lat_reg   <= '0;
            lat_addr  <= '0;
            resp_err  <= 1'b0;
            resp_wrap <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_store <= (cmd_op == OP_STORE);
                        lat_reg  <= cmd_reg;
                        lat_addr <= cmd_addr;
                        if (legal) begin
                            state     <= ST_EXEC;
                            mem_addr  <= cmd_addr;
                            mem_we    <= (cmd_op == OP_STORE);
                            mem_wdata <= (cmd_op == OP_STORE) ? vregs[cmd_reg] : '0;
                        end else begin
                            state     <= ST_RESP;
                            resp_err  <= 1'b1;
                            resp_wrap <= (int'(cmd_addr) > WRAP_LIMIT);
                        end
                    end
                end
                ST_EXEC: begin
                    state     <= ST_RESP;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                    resp_err  <= 1'b0;
                    resp_wrap <= (int'(lat_addr) > WRAP_LIMIT);
                end
                ST_RESP: begin
                    if (resp_take) begin
                        state     <= ST_IDLE;
                        resp_err  <= 1'b0;
                        resp_wrap <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The LOAD capture is the later assignment, so it wins over a datapath write to the same index.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                vregs[i] <= '0;
            end
        end else begin
            if (vr_wr_en) begin
                vregs[vr_wr_sel] <= vr_wr_data;
            end
            if (load_capture) begin
                vregs[lat_reg] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vec_lsu_initiator.sv
// Bench for vec_lsu_initiator: behavioural 512x32 memory plus a word-array/register-array
// reference of what memory and the vector registers should hold after each command.
module tb_vec_lsu_initiator;

    localparam int ADDR_W = 9;
    localparam int WORD_W = 32;
    localparam int LANES  = 16;
    localparam int NREGS  = 4;
    localparam int RSEL_W = 2;
    localparam int VW     = LANES * WORD_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [RSEL_W-1:0] cmd_reg;
    logic [ADDR_W-1:0] cmd_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_err;
    logic              resp_wrap;
    logic              vr_wr_en;
    logic [RSEL_W-1:0] vr_wr_sel;
    logic [VW-1:0]     vr_wr_data;
    logic [RSEL_W-1:0] vr_rd_sel;
    logic [VW-1:0]     vr_rd_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [VW-1:0]     mem_wdata;
    logic [VW-1:0]     mem_rdata;

    logic [WORD_W-1:0] mem     [DEPTH];
    logic [WORD_W-1:0] ref_mem [DEPTH];
    logic [VW-1:0]     ref_vreg [NREGS];

    logic              mem_clear;
    logic              pre_req;
    logic [ADDR_W-1:0] pre_addr;
    logic [VW-1:0]     pre_vec;
    int                we_cycles = 0;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    vec_lsu_initiator dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_reg    (cmd_reg),
        .cmd_addr   (cmd_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_err   (resp_err),
        .resp_wrap  (resp_wrap),
        .vr_wr_en   (vr_wr_en),
        .vr_wr_sel  (vr_wr_sel),
        .vr_wr_data (vr_wr_data),
        .vr_rd_sel  (vr_rd_sel),
        .vr_rd_data (vr_rd_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: combinational 16-lane read with modulo wrap, writes on the falling edge.
    for (genvar g = 0; g < LANES; g++) begin : g_rd
        logic [ADDR_W-1:0] rd_idx;
        assign rd_idx = mem_addr + ADDR_W'(g);
        assign mem_rdata[WORD_W*g +: WORD_W] = mem[rd_idx];
    end

    always @(negedge clk) begin : mem_write
        logic [ADDR_W-1:0] idx;
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        end
        if (pre_req) begin
            for (int i = 0; i < LANES; i++) begin
                idx = pre_addr + ADDR_W'(i);
                mem[idx] = pre_vec[WORD_W*i +: WORD_W];
            end
        end
        if (mem_we) begin
            we_cycles++;
            for (int i = 0; i < LANES; i++) begin
                idx = mem_addr + ADDR_W'(i);
                mem[idx] = mem_wdata[WORD_W*i +: WORD_W];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] op, input int r, input int a);
        cmd_valid = v;
        cmd_op    = op;
        cmd_reg   = RSEL_W'(r);
        cmd_addr  = ADDR_W'(a);
    endtask

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[WORD_W*i +: WORD_W] = $urandom;
        return v;
    endfunction

    function automatic logic [VW-1:0] ref_window(input int a);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[WORD_W*i +: WORD_W] = ref_mem[(a + i) % DEPTH];
        return v;
    endfunction

    function automatic logic [VW-1:0] mem_window(input int a);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[WORD_W*i +: WORD_W] = mem[(a + i) % DEPTH];
        return v;
    endfunction

    task automatic ref_store(input int a, input logic [VW-1:0] v);
        for (int i = 0; i < LANES; i++) ref_mem[(a + i) % DEPTH] = v[WORD_W*i +: WORD_W];
    endtask

    task automatic preload(input int a, input logic [VW-1:0] v);
        pre_addr = ADDR_W'(a);
        pre_vec  = v;
        pre_req  = 1'b1;
        @(negedge clk);
        #1;
        pre_req  = 1'b0;
        ref_store(a, v);
    endtask

    task automatic write_reg(input int r, input logic [VW-1:0] v);
        vr_wr_en   = 1'b1;
        vr_wr_sel  = RSEL_W'(r);
        vr_wr_data = v;
        tick();
        vr_wr_en   = 1'b0;
        ref_vreg[r] = v;
    endtask

    task automatic check_regs(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            vr_rd_sel = RSEL_W'(r);
            #1;
            checkOutput($sformatf("%s_vreg%0d", tag, r), vr_rd_data, ref_vreg[r]);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        checkOutput({tag, "_mem_image"}, VW'(bad), '0);
    endtask

    // One full command: accept, EXEC (or direct RESP when illegal), optional stall, handshake.
    task automatic run_cmd(input logic [1:0] op, input int r, input int a, input bit exec_wr,
                           input int ws, input logic [VW-1:0] wd, input int hold);
        logic [VW-1:0] snap;
        bit            legal;
        int            we0;
        legal = (op == 2'b00) || (op == 2'b01);
        snap  = ref_vreg[r];
        we0   = we_cycles;
        applyStimulus(1'b1, op, r, a);
        tick();
        applyStimulus(1'b0, 2'b00, 0, 0);
        if (exec_wr) begin
            vr_wr_en   = 1'b1;
            vr_wr_sel  = RSEL_W'(ws);
            vr_wr_data = wd;
        end
        if (legal) begin
            checkOutput("exec_cmd_ready", VW'(cmd_ready), '0);
            checkOutput("exec_resp_valid", VW'(resp_valid), '0);
            checkOutput("exec_mem_we", VW'(mem_we), VW'(op == 2'b01));
            checkOutput("exec_mem_addr", VW'(mem_addr), VW'(a));
            checkOutput("exec_mem_wdata", mem_wdata, (op == 2'b01) ? snap : '0);
        end else begin
            checkOutput("illegal_resp_valid", VW'(resp_valid), VW'(1));
            checkOutput("illegal_resp_err", VW'(resp_err), VW'(1));
            checkOutput("illegal_mem_we", VW'(mem_we), '0);
        end
        tick();
        vr_wr_en = 1'b0;
        if (op == 2'b01) ref_store(a, snap);
        if (exec_wr) ref_vreg[ws] = wd;
        if (op == 2'b00) ref_vreg[r] = ref_window(a);
        checkOutput("resp_valid", VW'(resp_valid), VW'(1));
        checkOutput("resp_err", VW'(resp_err), VW'(!legal));
        checkOutput("resp_wrap", VW'(resp_wrap), VW'(a > DEPTH - LANES));
        checkOutput("resp_cmd_ready", VW'(cmd_ready), '0);
        checkOutput("resp_mem_we", VW'(mem_we), '0);
        checkOutput("resp_mem_wdata", mem_wdata, '0);
        checkOutput("we_cycle_count", VW'(we_cycles - we0), VW'(op == 2'b01));
        if (hold > 0) applyStimulus(1'b1, 2'b01, (r + 1) % NREGS, (a + 3) % DEPTH);
        for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput("stall_resp_valid", VW'(resp_valid), VW'(1));
            checkOutput("stall_cmd_ready", VW'(cmd_ready), '0);
        end
        applyStimulus(1'b0, 2'b00, 0, 0);
        check_mem("cmd");
        check_regs("cmd");
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("done_cmd_ready", VW'(cmd_ready), VW'(1));
        checkOutput("done_resp_valid", VW'(resp_valid), '0);
        checkOutput("done_resp_flags", VW'({resp_err, resp_wrap}), '0);
    endtask

    initial begin
        logic [VW-1:0] v;
        logic [VW-1:0] lane_vec;
        logic [1:0]    rop;
        int            ra;
        int            we0;

        reset      = 1'b1;
        resp_ready = 1'b0;
        vr_wr_en   = 1'b0;
        vr_wr_sel  = '0;
        vr_wr_data = '0;
        vr_rd_sel  = '0;
        pre_req    = 1'b0;
        pre_addr   = '0;
        pre_vec    = '0;
        mem_clear  = 1'b1;
        applyStimulus(1'b0, 2'b00, 0, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int r = 0; r < NREGS; r++) ref_vreg[r] = '0;
        tick();
        mem_clear = 1'b0;
        tick();

        checkOutput("rst_cmd_ready", VW'(cmd_ready), VW'(1));
        checkOutput("rst_resp", VW'({resp_valid, resp_err, resp_wrap}), '0);
        checkOutput("rst_mem_we", VW'(mem_we), '0);
        checkOutput("rst_mem_addr", VW'(mem_addr), '0);
        checkOutput("rst_mem_wdata", mem_wdata, '0);
        check_regs("rst");
        reset = 1'b0;
        tick();

        $display("[TB] store reg1 at 0x040");
        for (int i = 0; i < LANES; i++) lane_vec[WORD_W*i +: WORD_W] = 32'(i + 1);
        write_reg(1, lane_vec);
        run_cmd(2'b01, 1, 'h040, 1'b0, 0, '0, 0);
        checkOutput("t1_mem_lanes", mem_window('h040), lane_vec);

        $display("[TB] wrapping load reg2 at 0x1F8");
        for (int i = 0; i < 8; i++) begin
            lane_vec[WORD_W*i +: WORD_W]     = 32'('hA0 + i);
            lane_vec[WORD_W*(i+8) +: WORD_W] = 32'('hB0 + i);
        end
        preload('h1F8, lane_vec);
        run_cmd(2'b00, 2, 'h1F8, 1'b0, 0, '0, 0);
        vr_rd_sel = 2'd2;
        #1;
        checkOutput("t2_lane0", VW'(vr_rd_data[0 +: 32]), VW'('hA0));
        checkOutput("t2_lane8", VW'(vr_rd_data[256 +: 32]), VW'('hB0));
        checkOutput("t2_lane15", VW'(vr_rd_data[480 +: 32]), VW'('hB7));

        $display("[TB] illegal opcode");
        run_cmd(2'b11, 0, 'h033, 1'b0, 0, '0, 0);
        run_cmd(2'b10, 3, 'h1FA, 1'b0, 0, '0, 0);

        $display("[TB] response stall with pending command");
        run_cmd(2'b01, 1, 'h1F5, 1'b0, 0, '0, 5);

        $display("[TB] load vs datapath write conflicts");
        preload('h010, rand_vec());
        run_cmd(2'b00, 0, 'h010, 1'b1, 0, '1, 0);
        checkOutput("t5_reg0_is_mem", ref_vreg[0], mem_window('h010));
        preload('h020, rand_vec());
        run_cmd(2'b00, 1, 'h020, 1'b1, 3, rand_vec(), 0);

        $display("[TB] store source snapshot");
        write_reg(2, rand_vec());
        run_cmd(2'b01, 2, 'h080, 1'b1, 2, rand_vec(), 0);

        $display("[TB] randomized commands");
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) write_reg($urandom_range(0, NREGS - 1), rand_vec());
            if ($urandom_range(0, 2) == 0) preload($urandom_range(0, DEPTH - 1), rand_vec());
            rop = ($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - LANES - 2, DEPTH - 1)
                                               : $urandom_range(0, DEPTH - 1);
            run_cmd(rop, $urandom_range(0, NREGS - 1), ra, 1'($urandom_range(0, 1)),
                    $urandom_range(0, NREGS - 1), rand_vec(), $urandom_range(0, 2));
        end

        $display("[TB] reset during RESP");
        applyStimulus(1'b1, 2'b00, 2, 'h100);
        tick();
        applyStimulus(1'b0, 2'b00, 0, 0);
        tick();
        checkOutput("t6a_resp_valid", VW'(resp_valid), VW'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < NREGS; r++) ref_vreg[r] = '0;
        checkOutput("t6a_resp_dropped", VW'(resp_valid), '0);
        checkOutput("t6a_cmd_ready", VW'(cmd_ready), VW'(1));
        check_regs("t6a");

        $display("[TB] reset during STORE EXEC");
        v = rand_vec();
        write_reg(3, v);
        we0 = we_cycles;
        applyStimulus(1'b1, 2'b01, 3, 'h0C7);
        tick();
        applyStimulus(1'b0, 2'b00, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_store('h0C7, v);
        for (int r = 0; r < NREGS; r++) ref_vreg[r] = '0;
        checkOutput("t6_resp_valid", VW'(resp_valid), '0);
        checkOutput("t6_cmd_ready", VW'(cmd_ready), VW'(1));
        checkOutput("t6_mem_we", VW'(mem_we), '0);
        checkOutput("t6_we_count", VW'(we_cycles - we0), VW'(1));
        checkOutput("t6_mem_lanes", mem_window('h0C7), v);
        tick();
        checkOutput("t6_no_resp_later", VW'(resp_valid), '0);
        check_mem("t6");
        check_regs("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
